cache_line_xfer_ctrl: RTL and testbench

Parametrised successor to the single-word cache miss controller. It sits between a direct-mapped cache array and the external memory port. It services three kinds of request:
- **Read miss:** optionally write back a dirty victim line as a word burst, then refill the line word by word and install it.
- **Write-through:** write a single word.
- **Explicit flush:** write back a dirty line without refilling.

All logic is synchronous to one clock.

---
 rtl/cache_pkg.sv | 47 ++++
 rtl/line_word_buffer.sv | 24 ++
 rtl/cache_line_xfer_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cache_line_xfer_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and width helpers for the cache line
// transfer controller (states, request kinds, line_out field layout).
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WT,
    S_EVICT,
    S_FILL,
    S_INSTALL,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    REQ_RD,
    REQ_WT,
    REQ_FL
  } req_t;

  // line_out = {tag, data, dirty, valid}
  localparam int VALID_POS = 0;
  localparam int DIRTY_POS = 1;
  localparam int DATA_POS  = 2;

  function automatic int tag_bits(
    input int aw,
    input int ib,
    input int bo
  );
    return aw - ib - bo;
  endfunction

  function automatic int words_per_line(
    input int ws,
    input int bo
  );
    return (1 << bo) / (ws / 8);
  endfunction

  function automatic int line_length(
    input int tb,
    input int bo
  );
    return tb + 8 * (1 << bo) + 2;
  endfunction

endpackage

// File: rtl/line_word_buffer.sv
// line_word_buffer: WORDS x WORD_SIZE refill storage, one indexed
// word write per cycle, synchronous clear. Ports: clk, clr, we, idx, wdata, data.
module line_word_buffer #(
  parameter int WORD_SIZE = 32,
  parameter int WORDS     = 16,
  localparam int IW       = $clog2(WORDS)
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       we,
  input  logic [IW-1:0]              idx,
  input  logic [WORD_SIZE-1:0]       wdata,
  output logic [WORDS*WORD_SIZE-1:0] data
);

  always_ff @(posedge clk) begin
    if (clr) begin
      data <= '0;
    end else if (we) begin
      data[int'(idx)*WORD_SIZE +: WORD_SIZE] <= wdata;
    end
  end

endmodule

// File: rtl/cache_line_xfer_ctrl.sv
// cache_line_xfer_ctrl: read-miss evict/refill, write-through and flush
// between a direct-mapped cache array (victim_*, line_*) and memory (ext_*).
module cache_line_xfer_ctrl
  import cache_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_BITS   = 5,
  parameter int BLOCK_OFFSET = 6,
  localparam int TAG_BITS    =
    tag_bits(ADDR_WIDTH, INDEX_BITS, BLOCK_OFFSET),
  localparam int LINE_BITS   = 8 * (1 << BLOCK_OFFSET),
  localparam int LINE_LENGTH =
    line_length(TAG_BITS, BLOCK_OFFSET)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   req_re,
  input  logic                   req_wr,
  input  logic                   req_flush,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [WORD_SIZE-1:0]   req_wdata,
  input  logic                   victim_valid,
  input  logic                   victim_dirty,
  input  logic [TAG_BITS-1:0]    victim_tag,
  input  logic [LINE_BITS-1:0]   victim_data,
  output logic [LINE_LENGTH-1:0] line_out,
  output logic                   line_we,
  output logic                   re_ack,
  output logic                   wr_ack,
  output logic                   flush_ack,
  output logic [ADDR_WIDTH-1:0]  ext_addr,
  output logic [WORD_SIZE-1:0]   ext_wdata,
  input  logic [WORD_SIZE-1:0]   ext_rdata,
  output logic                   ext_re,
  output logic                   ext_wr,
  input  logic                   ext_ack
);

  localparam int BPW = WORD_SIZE / 8;
  localparam int WPL =
    words_per_line(WORD_SIZE, BLOCK_OFFSET);
  localparam int KW  = $clog2(WPL);
  localparam int WB  = $clog2(BPW);
  localparam logic [KW-1:0] KMAX = KW'(WPL - 1);

  state_t               state;
  req_t                 rq;
  logic [KW-1:0]        k;
  logic                 last;
  logic                 clr;
  logic                 buf_we;
  logic [LINE_BITS-1:0] buf_data;
  logic                 dirty_hit;

  logic [ADDR_WIDTH-1:0] k_off;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] evict_base;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign clr       = rst || !enable;
  assign last      = (k == KMAX);
  assign buf_we    = (state == S_FILL) && ext_ack;
  assign dirty_hit = victim_valid && victim_dirty;

  line_word_buffer #(
    .WORD_SIZE(WORD_SIZE),
    .WORDS    (WPL)
  ) u_buf (
    .clk  (clk),
    .clr  (clr),
    .we   (buf_we),
    .idx  (k),
    .wdata(ext_rdata),
    .data (buf_data)
  );

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state <= S_IDLE;
      rq    <= REQ_RD;
      k     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_wr) begin
            rq    <= REQ_WT;
            state <= S_WT;
          end else if (req_flush) begin
            rq    <= REQ_FL;
            state <= dirty_hit ? S_EVICT : S_DONE;
          end else if (req_re) begin
            rq    <= REQ_RD;
            state <= dirty_hit ? S_EVICT : S_FILL;
          end
        end
        S_WT: begin
          if (ext_ack) state <= S_DONE;
        end
        S_EVICT: begin
          if (ext_ack) begin
            k <= k + 1'b1;
            if (last) begin
              state <= (rq == REQ_FL) ? S_DONE : S_FILL;
            end
          end
        end
        S_FILL: begin
          if (ext_ack) begin
            k <= k + 1'b1;
            if (last) state <= S_INSTALL;
          end
        end
        S_INSTALL: state <= S_DONE;
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign k_off      = ADDR_WIDTH'(k) << WB;
  assign line_base  = req_addr &
    ~ADDR_WIDTH'((1 << BLOCK_OFFSET) - 1);
  assign word_addr  = req_addr & ~ADDR_WIDTH'(BPW - 1);
  assign evict_base = {
    victim_tag,
    req_addr[BLOCK_OFFSET +: INDEX_BITS],
    BLOCK_OFFSET'(0)
  };

  // Everything below decodes from registered state only,
  // so ext_ack never reaches an output combinationally.
  assign ext_wr    = (state == S_WT) || (state == S_EVICT);
  assign ext_re    = (state == S_FILL);
  assign re_ack    = (state == S_DONE) && (rq == REQ_RD);
  assign wr_ack    = (state == S_DONE) && (rq == REQ_WT);
  assign flush_ack = (state == S_DONE) && (rq == REQ_FL);
  assign line_we   = (state == S_INSTALL) || flush_ack;

  always_comb begin
    ext_addr  = '0;
    ext_wdata = '0;
    unique case (1'b1)
      (state == S_WT): begin
        ext_addr  = word_addr;
        ext_wdata = req_wdata;
      end
      (state == S_EVICT): begin
        ext_addr  = evict_base | k_off;
        ext_wdata =
          victim_data[int'(k)*WORD_SIZE +: WORD_SIZE];
      end
      (state == S_FILL): begin
        ext_addr = line_base | k_off;
      end
      default: ;
    endcase
  end

  always_comb begin
    line_out = '0;
    unique case (1'b1)
      (state == S_INSTALL): begin
        line_out[VALID_POS] = 1'b1;
        line_out[DATA_POS +: LINE_BITS] = buf_data;
        line_out[DATA_POS+LINE_BITS +: TAG_BITS] =
          req_addr[ADDR_WIDTH-1 -: TAG_BITS];
      end
      flush_ack: begin
        line_out[VALID_POS] = victim_valid;
        line_out[DATA_POS +: LINE_BITS] = victim_data;
        line_out[DATA_POS+LINE_BITS +: TAG_BITS] =
          victim_tag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_line_xfer_ctrl.sv
// tb_cache_line_xfer_ctrl: scoreboard bench for cache_line_xfer_ctrl;
// expected memory transfers and line installs are queued then popped.
module tb_cache_line_xfer_ctrl;

  localparam int TAGB = 21;
  localparam int LB   = 512;
  localparam int LL   = 535;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            req_re;
  logic            req_wr;
  logic            req_flush;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            victim_valid;
  logic            victim_dirty;
  logic [TAGB-1:0] victim_tag;
  logic [LB-1:0]   victim_data;
  logic [LL-1:0]   line_out;
  logic            line_we;
  logic            re_ack;
  logic            wr_ack;
  logic            flush_ack;
  logic [31:0]     ext_addr;
  logic [31:0]     ext_wdata;
  logic [31:0]     ext_rdata;
  logic            ext_re;
  logic            ext_wr;
  logic            ext_ack;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t          exp_q[$];
  logic [LL-1:0] line_q[$];
  int            errors = 0;
  int            checks = 0;

  cache_line_xfer_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req_re      (req_re),
    .req_wr      (req_wr),
    .req_flush   (req_flush),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .victim_valid(victim_valid),
    .victim_dirty(victim_dirty),
    .victim_tag  (victim_tag),
    .victim_data (victim_data),
    .line_out    (line_out),
    .line_we     (line_we),
    .re_ack      (re_ack),
    .wr_ack      (wr_ack),
    .flush_ack   (flush_ack),
    .ext_addr    (ext_addr),
    .ext_wdata   (ext_wdata),
    .ext_rdata   (ext_rdata),
    .ext_re      (ext_re),
    .ext_wr      (ext_wr),
    .ext_ack     (ext_ack)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [LL-1:0] mk_line(
    input logic [TAGB-1:0] t,
    input logic [LB-1:0]   d,
    input logic            dirty,
    input logic            valid
  );
    return {t, d, dirty, valid};
  endfunction

  function automatic logic [LB-1:0] fill_data(
    input logic [31:0] base
  );
    logic [LB-1:0] d;
    for (int i = 0; i < 16; i++)
      d[i*32 +: 32] = base + 32'(4 * i);
    return d;
  endfunction

  function automatic logic [LB-1:0] vic_data(
    input logic [31:0] seed
  );
    logic [LB-1:0] d;
    for (int i = 0; i < 16; i++)
      d[i*32 +: 32] = seed + 32'(i) * 32'h0001_0101;
    return d;
  endfunction

  task automatic push_fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{1'b0, base + 32'(4 * i), 32'h0});
  endtask

  task automatic push_evict(
    input logic [TAGB-1:0] t,
    input logic [4:0]      idx,
    input logic [LB-1:0]   d
  );
    logic [31:0] b;
    b = {t, idx, 6'd0};
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{1'b1, b + 32'(4 * i), d[i*32 +: 32]});
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if ({ext_re, ext_wr, line_we, re_ack, wr_ack, flush_ack} !== 6'b0) begin
      errors++;
      $display("FAIL %s strobes: got %b want 000000", tag,
        {ext_re, ext_wr, line_we, re_ack, wr_ack, flush_ack});
    end
    checks++;
    if ({ext_addr, ext_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL %s ext bus: got addr %h data %h want 0", tag,
        ext_addr, ext_wdata);
    end
    checks++;
    if (line_out !== '0) begin
      errors++;
      $display("FAIL %s line_out: got %h want 0", tag, line_out);
    end
  endtask

  // Memory responder + checker. Sampling edge is the first posedge;
  // cycle c counts cycles after it. stop_after>0 returns right after
  // the ack for that many words has been driven.
  task automatic service(
    input string      name,
    input int         waits,
    input int         stop_after,
    input logic [2:0] exp_ack,
    input int         exp_lat,
    input int         exp_lwe
  );
    int          c;
    int          wc;
    int          nack;
    int          nlwe;
    bit          done;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_wr;
    txn_t        e;
    logic [LL-1:0] le;
    c = 0; wc = 0; nack = 0; nlwe = 0; done = 0;
    h_addr = '0; h_wdata = '0; h_wr = 1'b0;
    @(posedge clk);
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
      ext_ack = 1'b0;
      if (ext_re || ext_wr) begin
        if (wc == 0) begin
          h_addr = ext_addr; h_wdata = ext_wdata; h_wr = ext_wr;
        end else begin
          checks++;
          if ({ext_wr, ext_addr, ext_wdata} !== {h_wr, h_addr, h_wdata}) begin
            errors++;
            $display("FAIL %s hold c=%0d: got %b %h %h want %b %h %h",
              name, c, ext_wr, ext_addr, ext_wdata, h_wr, h_addr, h_wdata);
          end
        end
        if (wc < waits) begin
          wc++;
        end else begin
          wc = 0;
          ext_ack = 1'b1;
          ext_rdata = ext_addr;
          nack++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s xfer: got unexpected wr=%b addr %h, want none",
              name, ext_wr, ext_addr);
          end else begin
            e = exp_q.pop_front();
            if ({ext_wr, ext_re, ext_addr, ext_wdata} !==
                {e.wr, ~e.wr, e.addr, e.data}) begin
              errors++;
              $display("FAIL %s xfer %0d: got wr=%b re=%b %h %h want wr=%b %h %h",
                name, nack, ext_wr, ext_re, ext_addr, ext_wdata,
                e.wr, e.addr, e.data);
            end
          end
          if (nack == stop_after) return;
        end
      end
      if (line_we) begin
        nlwe++;
        checks++;
        if (line_q.size() == 0) begin
          errors++;
          $display("FAIL %s line_we: got unexpected pulse, want none", name);
        end else begin
          le = line_q.pop_front();
          if (line_out !== le) begin
            errors++;
            $display("FAIL %s line_out: got %h want %h", name, line_out, le);
          end
        end
      end
      if (re_ack || wr_ack || flush_ack) begin
        done = 1;
        checks++;
        if ({re_ack, wr_ack, flush_ack} !== exp_ack) begin
          errors++;
          $display("FAIL %s ack kind: got %b want %b", name,
            {re_ack, wr_ack, flush_ack}, exp_ack);
        end
        checks++;
        if (c != exp_lat) begin
          errors++;
          $display("FAIL %s latency: got %0d want %0d", name, c, exp_lat);
        end
      end
    end
    ext_ack = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no ack want ack %b", name, exp_ack);
    end
    checks++;
    if (nlwe != exp_lwe) begin
      errors++;
      $display("FAIL %s line_we count: got %0d want %0d", name, nlwe, exp_lwe);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s xfers left: got %0d pending want 0", name, exp_q.size());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1;
    req_re = 0; req_wr = 0; req_flush = 0;
    req_addr = '0; req_wdata = '0;
    victim_valid = 0; victim_dirty = 0;
    victim_tag = '0; victim_data = '0;
    ext_rdata = '0; ext_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    ext_ack = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_clean_read;
    victim_valid = 1; victim_dirty = 0;
    victim_tag = 21'h00_0123;
    victim_data = vic_data(32'h1111_0000);
    req_addr = 32'h0000_1234;
    push_fill(32'h0000_1200);
    line_q.push_back(mk_line(21'd2, fill_data(32'h1200), 1'b0, 1'b1));
    req_re = 1;
    service("clean_read", 0, 0, 3'b100, 18, 1);
    req_re = 0;
  endtask

  task automatic test_dirty_read;
    logic [LB-1:0] vd;
    vd = vic_data(32'hA500_0000);
    victim_valid = 1; victim_dirty = 1;
    victim_tag = 21'h2AB; victim_data = vd;
    req_addr = 32'h0000_28D0;
    push_evict(21'h2AB, 5'd3, vd);
    push_fill(32'h0000_28C0);
    line_q.push_back(mk_line(21'd5, fill_data(32'h28C0), 1'b0, 1'b1));
    req_re = 1;
    service("dirty_read", 1, 0, 3'b100, 66, 1);
    req_re = 0;
  endtask

  task automatic test_write_through;
    victim_valid = 1; victim_dirty = 1;
    req_addr = 32'h0000_0106;
    req_wdata = 32'hDEAD_BEEF;
    exp_q.push_back('{1'b1, 32'h0000_0104, 32'hDEAD_BEEF});
    req_wr = 1;
    service("write_through", 3, 0, 3'b010, 5, 0);
    req_wr = 0;
  endtask

  task automatic test_simultaneous;
    logic [LB-1:0] vd;
    vd = vic_data(32'h5A5A_0000);
    victim_valid = 1; victim_dirty = 0;
    victim_tag = 21'h77; victim_data = vd;
    req_addr = 32'h0000_4008;
    req_wdata = 32'h0BAD_F00D;
    exp_q.push_back('{1'b1, 32'h0000_4008, 32'h0BAD_F00D});
    req_wr = 1; req_flush = 1; req_re = 1;
    service("simul_wt", 0, 0, 3'b010, 2, 0);
    req_wr = 0;
    line_q.push_back(mk_line(21'h77, vd, 1'b0, 1'b1));
    service("simul_flush", 0, 0, 3'b001, 1, 1);
    req_flush = 0; req_re = 0;
  endtask

  task automatic test_reset_mid_burst;
    victim_valid = 0; victim_dirty = 0;
    req_addr = 32'h0000_1234;
    push_fill(32'h0000_1200);
    req_re = 1;
    service("rst_burst", 0, 5, 3'b100, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ext_ack = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("rst_burst");
    end
    rst = 1'b0;
    push_fill(32'h0000_1200);
    line_q.push_back(mk_line(21'd2, fill_data(32'h1200), 1'b0, 1'b1));
    service("rst_restart", 0, 0, 3'b100, 18, 1);
    req_re = 0;
  endtask

  task automatic test_enable_drop;
    logic [LB-1:0] vd;
    int            seen;
    vd = vic_data(32'hC3C3_0000);
    victim_valid = 1; victim_dirty = 1;
    victim_tag = 21'h2AB; victim_data = vd;
    req_addr = 32'h0000_28D0;
    push_evict(21'h2AB, 5'd3, vd);
    req_flush = 1;
    service("en_drop", 0, 3, 3'b001, 0, 0);
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    ext_ack = 1'b1;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ext_re || ext_wr || line_we || re_ack || wr_ack || flush_ack)
        seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL en_drop activity: got %0d cycles want 0", seen);
    end
    check_quiet("en_drop");
    req_flush = 0;
    ext_ack = 1'b0;
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_read();
    test_dirty_read();
    test_write_through();
    test_simultaneous();
    test_reset_mid_burst();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
